ray_aabb_result_aligner: RTL and testbench

- Downstream companion of the pipelined ray/AABB intersection core (FloPoCo wE=11, wF=14, 28-bit operands). The core has a fixed latency and no valid/stall signals.
- The block issues launch credits to the upstream ray feeder and carries {valid, tag} through a delay line matched to the core latency.
- It pairs each returning core hit/miss bit with its ray tag and buffers the results in a FIFO with a ready/valid output.
- It keeps saturating hit/miss statistics.

---
 rtl/ray_aabb_pkg.sv | 28 ++
 rtl/ray_result_fifo.sv | 87 ++++++++
 rtl/ray_aabb_result_aligner.sv | 145 ++++++++++++++
 tb/tb_ray_aabb_result_aligner.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_aabb_pkg.sv
// ----------------------------------------------------------------------------
// ray_aabb_pkg
// Shared constants and types for the ray/AABB intersection back end.
//   - FP_WE/FP_WF/FP_W : FloPoCo operand format of the intersection core
//                        (exponent, fraction, total width incl. 2 exception
//                        bits and the sign bit).
//   - RAY_AABB_LATENCY : fixed core latency, launch to hit bit.
//   - RAY_TAG_W        : ray identifier width.
//   - ray_result_t     : retired result record {tag, hit}.
// ----------------------------------------------------------------------------
package ray_aabb_pkg;

    localparam int unsigned FP_WE = 11;
    localparam int unsigned FP_WF = 14;
    localparam int unsigned FP_W  = FP_WE + FP_WF + 3;

    localparam int unsigned RAY_AABB_LATENCY = 42;
    localparam int unsigned RAY_TAG_W        = 16;
    localparam int unsigned RAY_FIFO_DEPTH   = 16;
    localparam int unsigned RAY_CNT_W        = 32;

    // One retired ray: identifier plus the core's hit/miss decision.
    typedef struct packed {
        logic [RAY_TAG_W-1:0] tag;
        logic                 hit;
    } ray_result_t;

endpackage

// File: rtl/ray_result_fifo.sv
// ----------------------------------------------------------------------------
// ray_result_fifo
// Synchronous FIFO with a registered head (no write-to-read bypass): an entry
// pushed in cycle t is first visible on out_valid/out_data in cycle t+1.
// The head register only changes when the head entry changes, so out_data is
// stable while out_valid=1 and pop=0.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   push        write push_data (ignored when full without a pop)
//   push_data   entry to store
//   pop         consume the head (ignored while out_valid=0)
//   out_valid   head entry valid
//   out_data    head entry
//   count       number of stored entries (0..DEPTH)
// DEPTH must be a power of two and at least 2; pointers wrap naturally.
// ----------------------------------------------------------------------------
module ray_result_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             do_push;
    logic             do_pop;
    logic             head_from_push;

    // Accepted push/pop and next pointer/occupancy.
    always_comb begin
        do_pop         = pop & out_valid;
        do_push        = push & ((count != CNT_W'(DEPTH)) | do_pop);
        rd_ptr_nxt     = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_nxt      = count;
        // New head is the entry being written this cycle (FIFO empty, or
        // its last entry is being popped).
        head_from_push = do_push & (rd_ptr_nxt == wr_ptr);
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                out_data <= head_from_push ? push_data : mem[rd_ptr_nxt];
            end
        end
    end

endmodule

// File: rtl/ray_aabb_result_aligner.sv
// ----------------------------------------------------------------------------
// ray_aabb_result_aligner
// Aligns the hit/miss bit of a fixed-latency, non-stallable ray/AABB core with
// the tag of the ray that produced it, buffers results in a FIFO and keeps
// saturating hit/miss statistics. Launch credits to the feeder guarantee the
// FIFO can absorb every ray already in the core.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     feeder has a ray on the core inputs
//   in_ready     launch permitted this cycle (combinational credit check)
//   in_tag       tag of the ray being launched
//   core_hit     hit/miss output of the core
//   out_valid    result FIFO head valid
//   out_ready    consumer accepts the head
//   out_tag      tag of the head result
//   out_hit      hit bit of the head result
//   hit_count    saturating count of retired hits
//   miss_count   saturating count of retired misses
//   busy         a ray is in flight or the FIFO holds a result
// Build option: RAY_AABB_HITS_ONLY_EN - when defined, only hits are pushed to
// the FIFO; misses still retire credits and update miss_count.
// ----------------------------------------------------------------------------
module ray_aabb_result_aligner
    import ray_aabb_pkg::*;
#(
    parameter int unsigned LATENCY    = RAY_AABB_LATENCY,
    parameter int unsigned TAG_W      = RAY_TAG_W,
    parameter int unsigned FIFO_DEPTH = RAY_FIFO_DEPTH,
    parameter int unsigned CNT_W      = RAY_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             core_hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_hit,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic             busy
);

    localparam int unsigned INF_W  = $clog2(LATENCY + FIFO_DEPTH) + 1;
    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned SUM_W  = INF_W + 1;
    localparam int unsigned RES_W  = TAG_W + 1;

    logic [LATENCY-1:0] dl_valid;
    logic [TAG_W-1:0]   dl_tag [LATENCY];
    logic [INF_W-1:0]   inflight;
    logic [FCNT_W-1:0]  fifo_count;
    logic [SUM_W-1:0]   credit_sum;
    logic               launch;
    logic               retire;
    logic               push;
    logic [RES_W-1:0]   push_data;
    logic [RES_W-1:0]   head_data;

    // Every ray in the core or in the FIFO holds one of FIFO_DEPTH credits.
    assign credit_sum = SUM_W'(fifo_count) + SUM_W'(inflight);
    assign in_ready   = (credit_sum < SUM_W'(FIFO_DEPTH));
    assign busy       = (inflight != '0) | (fifo_count != '0);

    // Launch/retire decode and result record for the FIFO.
    always_comb begin
        launch    = in_valid & in_ready;
        retire    = dl_valid[LATENCY-1];
        push_data = {dl_tag[LATENCY-1], core_hit};
`ifdef RAY_AABB_HITS_ONLY_EN
        push      = retire & core_hit;
`else
        push      = retire;
`endif
    end

    // Valid bits of the delay line; reset clears rays still in the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            dl_valid <= '0;
        end else begin
            dl_valid[0] <= launch;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                dl_valid[i] <= dl_valid[i-1];
            end
        end
    end

    // Tag payload of the delay line; only meaningful where valid is set.
    always_ff @(posedge clk) begin
        dl_tag[0] <= in_tag;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            dl_tag[i] <= dl_tag[i-1];
        end
    end

    // Rays launched but not yet retired.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else if (launch & ~retire) begin
            inflight <= inflight + INF_W'(1);
        end else if (~launch & retire) begin
            inflight <= inflight - INF_W'(1);
        end
    end

    // Saturating hit/miss statistics of retired rays.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (retire) begin
            if (core_hit) begin
                if (hit_count != '1) begin
                    hit_count <= hit_count + CNT_W'(1);
                end
            end else begin
                if (miss_count != '1) begin
                    miss_count <= miss_count + CNT_W'(1);
                end
            end
        end
    end

    ray_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (RES_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (head_data),
        .count     (fifo_count)
    );

    assign out_tag = head_data[RES_W-1:1];
    assign out_hit = head_data[0];

endmodule

// File: tb/tb_ray_aabb_result_aligner.sv
`timescale 1ns/1ps
module tb_ray_aabb_result_aligner;
    import ray_aabb_pkg::*;

    localparam int unsigned LAT   = RAY_AABB_LATENCY;
    localparam int unsigned TW    = RAY_TAG_W;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned SAT_W = 4;
    localparam int          SAT_MAX = 15;
`ifdef RAY_AABB_HITS_ONLY_EN
    localparam bit HITS_ONLY = 1'b1;
`else
    localparam bit HITS_ONLY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          core_hit = 1'b0;
    logic          out_ready = 1'b0;

    logic             in_ready, out_valid, out_hit, busy;
    logic [TW-1:0]    out_tag;
    logic [31:0]      hit_count, miss_count;
    logic             sat_in_ready, sat_out_valid, sat_out_hit, sat_busy;
    logic [TW-1:0]    sat_out_tag;
    logic [SAT_W-1:0] sat_hit_count, sat_miss_count;

    always #5 clk = ~clk;

    ray_aabb_result_aligner u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_tag(in_tag), .core_hit(core_hit), .out_valid(out_valid),
        .out_ready(out_ready), .out_tag(out_tag), .out_hit(out_hit),
        .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
    );

    ray_aabb_result_aligner #(.CNT_W(SAT_W)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_tag(in_tag), .core_hit(core_hit), .out_valid(sat_out_valid),
        .out_ready(out_ready), .out_tag(sat_out_tag), .out_hit(sat_out_hit),
        .hit_count(sat_hit_count), .miss_count(sat_miss_count), .busy(sat_busy)
    );

    // Model state: rays in the core keyed by retire cycle, and the FIFO.
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    ray_result_t sched [int];
    ray_result_t sb_q [$];
    int          exp_hits = 0;
    int          exp_misses = 0;
    bit          next_hit = 1'b0;
    bit          idle_hit_one = 1'b0;
    bit          last_launch = 1'b0;
    int          dut_pops = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT_MAX) ? SAT_MAX : v;
    endfunction

    // Compare DUT state right after an edge against the model.
    task automatic post_checks();
        bit exp_ready;
        bit exp_valid;
        bit exp_busy;
        exp_ready = (sb_q.size() + sched.size()) < DEPTH;
        exp_valid = (sb_q.size() != 0);
        exp_busy  = exp_valid || (sched.size() != 0);
        check("in_ready", in_ready, exp_ready);
        check("out_valid", out_valid, exp_valid);
        check("busy", busy, exp_busy);
        check("hit_count", hit_count, exp_hits);
        check("miss_count", miss_count, exp_misses);
        check("sat_hit_count", sat_hit_count, sat(exp_hits));
        check("sat_miss_count", sat_miss_count, sat(exp_misses));
        check("sat_ctl", {sat_in_ready, sat_out_valid, sat_busy}, {exp_ready, exp_valid, exp_busy});
        if (exp_valid) begin
            check("out_tag", out_tag, sb_q[0].tag);
            check("out_hit", out_hit, sb_q[0].hit);
            check("sat_out_head", {sat_out_tag, sat_out_hit}, {sb_q[0].tag, sb_q[0].hit});
        end
    endtask

    // One clock: drive core_hit from the model, update model, step, check.
    task automatic cycle();
        bit          can_launch;
        ray_result_t r;
        if (out_valid && out_ready) dut_pops++;
        if (rst) begin
            sched.delete();
            sb_q.delete();
            exp_hits    = 0;
            exp_misses  = 0;
            last_launch = 1'b0;
            core_hit    = idle_hit_one ? 1'b1 : 1'($urandom_range(0, 1));
        end else begin
            can_launch = (sb_q.size() + sched.size()) < DEPTH;
            if (out_ready && sb_q.size() != 0) void'(sb_q.pop_front());
            if (sched.exists(cyc)) begin
                r        = sched[cyc];
                core_hit = r.hit;
                sched.delete(cyc);
                if (r.hit) exp_hits++; else exp_misses++;
                if (r.hit || !HITS_ONLY) sb_q.push_back(r);
            end else begin
                core_hit = idle_hit_one ? 1'b1 : 1'($urandom_range(0, 1));
            end
            last_launch = in_valid && can_launch;
            if (last_launch) begin
                r.tag = in_tag;
                r.hit = next_hit;
                sched[cyc + int'(LAT)] = r;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        post_checks();
    endtask

    task automatic send(input logic [TW-1:0] tag, input bit hit);
        bit ok;
        in_valid = 1'b1;
        in_tag   = tag;
        next_hit = hit;
        ok       = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            cycle();
            ok = last_launch;
        end
        check("send_accept", ok, 1'b1);
    endtask

    task automatic drain(input int bound);
        in_valid = 1'b0;
        for (int i = 0; i < bound && (sb_q.size() != 0 || sched.size() != 0); i++) cycle();
        check("drain_done", sb_q.size() + sched.size(), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;
        int h0;
        int m0;
        int p0;
        bit seen;
        bit pat [10];

        // Reset state
        rst = 1'b1;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_tag", {out_tag, out_hit}, 0);
        check("rst_busy", busy, 1'b0);
        repeat (4) cycle();

        // 1: single launch, latency LAT+1, stable head until popped
        out_ready = 1'b0;
        t0 = cyc;
        send(16'h0005, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 80 && !out_valid; i++) cycle();
        check("t1_latency", cyc - t0, LAT + 1);
        check("t1_tag", out_tag, 16'h0005);
        check("t1_hit", out_hit, 1'b1);
        check("t1_hits", hit_count, 1);
        check("t1_misses", miss_count, 0);
        repeat (3) cycle();
        out_ready = 1'b1;
        cycle();
        check("t1_busy", busy, 1'b0);

        // 2: 100 rays, alternating hit/miss, consumer always ready
        for (int i = 0; i < 100; i++) send(TW'(i), (i % 2) == 0);
        drain(400);
        check("t2_hits", hit_count, 51);
        check("t2_misses", miss_count, 50);

        // 3: credit limit with a stalled consumer
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_tag    = 16'h0100;
        next_hit  = 1'b1;
        n = 0;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (last_launch) begin
                n++;
                in_tag = in_tag + TW'(1);
            end
        end
        check("t3_launches", n, 16);
        check("t3_in_ready_low", in_ready, 1'b0);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("t3_in_ready_back", in_ready, 1'b1);
        cycle();
        if (last_launch) n++;
        check("t3_extra_launch", n, 17);
        in_valid = 1'b0;
        cycle();
        check("t3_in_ready_full", in_ready, 1'b0);
        out_ready = 1'b1;
        drain(200);

        // 5: reset with rays in flight, then spurious core hits
        for (int i = 0; i < 14; i++) send(TW'(16'h0200 + i), 1'b1);
        in_valid = 1'b0;
        repeat (5) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t5_out_valid", out_valid, 1'b0);
        check("t5_hits", hit_count, 0);
        check("t5_busy", busy, 1'b0);
        check("t5_in_ready", in_ready, 1'b1);
        idle_hit_one = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            seen |= out_valid;
        end
        idle_hit_one = 1'b0;
        check("t5_no_output", seen, 1'b0);
        check("t5_hits_after", hit_count, 0);
        check("t5_sat_after", sat_hit_count, 0);

        // 4: saturation of the narrow counter
        for (int i = 0; i < 20; i++) send(TW'(16'h0300 + i), 1'b1);
        drain(300);
        check("t4_sat_hits", sat_hit_count, 15);
        check("t4_hits", hit_count, 20);

        // 6: mixed pattern; only hits emerge when HITS_ONLY build
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        h0 = int'(hit_count);
        m0 = int'(miss_count);
        p0 = dut_pops;
        for (int i = 0; i < 10; i++) send(TW'(i), pat[i]);
        drain(200);
        repeat (2) cycle();
        check("t6_hits", int'(hit_count) - h0, 4);
        check("t6_misses", int'(miss_count) - m0, 6);
        check("t6_outputs", dut_pops - p0, HITS_ONLY ? 4 : 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
